// File: rtl/native_arb_pkg.sv
// Shared state encoding, default widths and the round-robin helper for the native-port arbiter.
package native_arb_pkg;

  localparam int unsigned MAX_PORTS          = 8;
  localparam int unsigned MAX_PTR_W          = 3;
  localparam int unsigned DEF_NUM_PORTS      = 2;
  localparam int unsigned DEF_ADDR_W         = 32;
  localparam int unsigned DEF_DATA_W         = 256;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } arb_state_e;

  // First set bit of req at or above ptr, wrapping modulo n; one-hot, zero when req is empty.
  function automatic logic [MAX_PORTS-1:0] rr_next(input logic [MAX_PTR_W-1:0] ptr,
                                                   input logic [MAX_PORTS-1:0] req,
                                                   input int unsigned          n);
    logic [MAX_PORTS-1:0] win;
    logic                 found;
    int unsigned          idx;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < MAX_PORTS; i++) begin
      if (i < n) begin
        idx = (32'(ptr) + i) % n;
        if (!found && req[idx[MAX_PTR_W-1:0]]) begin
          win[idx[MAX_PTR_W-1:0]] = 1'b1;
          found                   = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/native_rr_picker.sv
// Combinational round-robin winner select: zero latency, no backpressure (pure function of req and pointer).
module native_rr_picker
  import native_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = DEF_NUM_PORTS,
  parameter int unsigned PTR_W     = $clog2(DEF_NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [PTR_W-1:0]     rr_ptr_i,
  output logic [NUM_PORTS-1:0] win_o,
  output logic                 any_o
);

  logic [MAX_PORTS-1:0] win_full;

  assign win_full = rr_next(MAX_PTR_W'(rr_ptr_i), MAX_PORTS'(req_i), NUM_PORTS);
  assign win_o    = win_full[NUM_PORTS-1:0];
  assign any_o    = |win_full;

endmodule

// File: rtl/native_port_arbiter.sv
// Locks one LPDDR4 native port to a round-robin winner until its data beat completes; grant 1 cycle after request,
// controller ready/valid forwarded combinationally to the owner. NATIVE_ARB_TIMEOUT_EN adds a lock watchdog.
module native_port_arbiter
  import native_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS      = DEF_NUM_PORTS,
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic [NUM_PORTS-1:0]          req_cmd_valid,
  output logic [NUM_PORTS-1:0]          req_cmd_ready,
  input  logic [NUM_PORTS-1:0]          req_cmd_we,
  input  logic [NUM_PORTS*ADDR_W-1:0]   req_cmd_addr,
  input  logic [NUM_PORTS-1:0]          req_wdata_valid,
  output logic [NUM_PORTS-1:0]          req_wdata_ready,
  input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata_data,
  input  logic [NUM_PORTS*DATA_W/8-1:0] req_wdata_we,
  output logic [NUM_PORTS-1:0]          req_rdata_valid,
  input  logic [NUM_PORTS-1:0]          req_rdata_ready,
  output logic [DATA_W-1:0]             req_rdata_data,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic                          cmd_last,
  output logic                          cmd_payload_we,
  output logic [ADDR_W-1:0]             cmd_payload_addr,
  output logic                          wdata_valid,
  input  logic                          wdata_ready,
  output logic [DATA_W-1:0]             wdata_payload_data,
  output logic [DATA_W/8-1:0]           wdata_payload_we,
  input  logic                          rdata_valid,
  output logic                          rdata_ready,
  input  logic [DATA_W-1:0]             rdata_payload_data,
  output logic [NUM_PORTS-1:0]          grant,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned PTR_W = $clog2(NUM_PORTS);

  if (NUM_PORTS < 2 || NUM_PORTS > MAX_PORTS) begin : g_bad_ports
    $error("native_port_arbiter: NUM_PORTS must be within 2..8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("native_port_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_e           state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]     own_q, own_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0] pick_win;
  logic                 pick_any;
  logic [PTR_W-1:0]     pick_idx;
  logic [PTR_W-1:0]     ptr_after;
  logic                 done;
  logic                 wd_expire;

  native_rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_picker (
    .req_i    (req_cmd_valid),
    .rr_ptr_i (rr_ptr_q),
    .win_o    (pick_win),
    .any_o    (pick_any)
  );

  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (pick_win[i]) pick_idx = PTR_W'(i);
    end
  end

  assign ptr_after = (own_q == PTR_W'(NUM_PORTS - 1)) ? '0 : own_q + 1'b1;

`ifdef NATIVE_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             in_data_phase;

  // Counts cycles spent waiting for the data beat; zero on the first WDATA/RDATA cycle.
  assign in_data_phase = (state_q == WDATA) || (state_q == RDATA);
  assign wd_cnt_d      = in_data_phase ? wd_cnt_q + 1'b1 : '0;
  assign wd_expire     = in_data_phase && (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) wd_cnt_q <= '0;
    else            wd_cnt_q <= wd_cnt_d;
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    own_d       = own_q;
    rr_ptr_d    = rr_ptr_q;
    done        = 1'b0;
    timeout_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = CMD;
          grant_d = pick_win;
          own_d   = pick_idx;
        end
      end
      CMD: begin
        // A requester withdrawing before the handshake gives up its turn without moving the pointer.
        if (!req_cmd_valid[own_q]) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (cmd_ready) begin
          state_d = req_cmd_we[own_q] ? WDATA : RDATA;
        end
      end
      WDATA:   done = wdata_valid & wdata_ready;
      RDATA:   done = rdata_valid & rdata_ready;
      default: state_d = IDLE;
    endcase
    if (done || wd_expire) begin
      state_d     = IDLE;
      grant_d     = '0;
      rr_ptr_d    = ptr_after;
      timeout_err = ~done;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      own_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      own_q    <= own_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Outside RDATA the return channel stays ready so stray beats drain without reaching any requester.
  always_comb begin
    cmd_valid       = 1'b0;
    req_cmd_ready   = '0;
    wdata_valid     = 1'b0;
    req_wdata_ready = '0;
    req_rdata_valid = '0;
    rdata_ready     = 1'b1;
    case (state_q)
      CMD: begin
        cmd_valid            = req_cmd_valid[own_q];
        req_cmd_ready[own_q] = cmd_ready;
      end
      WDATA: begin
        wdata_valid            = req_wdata_valid[own_q];
        req_wdata_ready[own_q] = wdata_ready;
      end
      RDATA: begin
        req_rdata_valid[own_q] = rdata_valid;
        rdata_ready            = req_rdata_ready[own_q];
      end
      default: ;
    endcase
  end

  assign cmd_payload_we     = req_cmd_we[own_q];
  assign cmd_last           = ~cmd_payload_we;
  assign cmd_payload_addr   = req_cmd_addr[own_q*ADDR_W +: ADDR_W];
  assign wdata_payload_data = req_wdata_data[own_q*DATA_W +: DATA_W];
  assign wdata_payload_we   = req_wdata_we[own_q*BE_W +: BE_W];
  assign req_rdata_data     = rdata_payload_data;
  assign grant              = grant_q;
  assign busy               = (state_q != IDLE);

endmodule

// File: tb/tb_native_port_arbiter.sv
// Directed bench for native_port_arbiter: per-cycle vector table plus hand sequences for reset and watchdog.
module tb_native_port_arbiter;

  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int BW = DW / 8;
  localparam int NV = 30;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic [NP-1:0]     req_cmd_valid, req_cmd_ready, req_cmd_we;
  logic [NP*AW-1:0]  req_cmd_addr;
  logic [NP-1:0]     req_wdata_valid, req_wdata_ready;
  logic [NP*DW-1:0]  req_wdata_data;
  logic [NP*BW-1:0]  req_wdata_we;
  logic [NP-1:0]     req_rdata_valid, req_rdata_ready;
  logic [DW-1:0]     req_rdata_data;
  logic              cmd_valid, cmd_ready, cmd_last, cmd_payload_we;
  logic [AW-1:0]     cmd_payload_addr;
  logic              wdata_valid, wdata_ready;
  logic [DW-1:0]     wdata_payload_data;
  logic [BW-1:0]     wdata_payload_we;
  logic              rdata_valid, rdata_ready;
  logic [DW-1:0]     rdata_payload_data;
  logic [NP-1:0]     grant;
  logic              busy, timeout_err;

  always #5 sys_clk = ~sys_clk;

  native_port_arbiter #(
    .NUM_PORTS      (NP),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .sys_clk            (sys_clk),
    .sys_rst_n          (sys_rst_n),
    .req_cmd_valid      (req_cmd_valid),
    .req_cmd_ready      (req_cmd_ready),
    .req_cmd_we         (req_cmd_we),
    .req_cmd_addr       (req_cmd_addr),
    .req_wdata_valid    (req_wdata_valid),
    .req_wdata_ready    (req_wdata_ready),
    .req_wdata_data     (req_wdata_data),
    .req_wdata_we       (req_wdata_we),
    .req_rdata_valid    (req_rdata_valid),
    .req_rdata_ready    (req_rdata_ready),
    .req_rdata_data     (req_rdata_data),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_last           (cmd_last),
    .cmd_payload_we     (cmd_payload_we),
    .cmd_payload_addr   (cmd_payload_addr),
    .wdata_valid        (wdata_valid),
    .wdata_ready        (wdata_ready),
    .wdata_payload_data (wdata_payload_data),
    .wdata_payload_we   (wdata_payload_we),
    .rdata_valid        (rdata_valid),
    .rdata_ready        (rdata_ready),
    .rdata_payload_data (rdata_payload_data),
    .grant              (grant),
    .busy               (busy),
    .timeout_err        (timeout_err)
  );

  typedef struct {
    logic       rst_n;
    logic [1:0] cv, cwe, wv, rrdy;
    logic       crdy, wrdy, rv;
    logic [15:0] rd;
    logic       e_cv, e_cwe;
    logic [1:0] e_crdy;
    logic       e_wv;
    logic [1:0] e_wrdy, e_rv;
    logic       e_rrdy;
    logic [1:0] e_gnt;
    logic       e_busy;
    int         e_own;
  } vec_t;

  vec_t          vecs [NV];
  logic [AW-1:0] addr_c [NP];
  logic [DW-1:0] dat_c [NP];
  logic [BW-1:0] be_c [NP];
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string nm, input int idx, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %0h expected %0h", nm, idx, got, exp);
    end
  endtask

  task automatic chk_w(input string nm, input int idx, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got ..%0h expected ..%0h", nm, idx, got[63:0], exp[63:0]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    logic exp_last;
    int   n;

    addr_c[0] = 32'h0000_0100;
    addr_c[1] = 32'h0000_0200;
    dat_c[0]  = {32{8'hA5}};
    dat_c[1]  = {32{8'h5A}};
    be_c[0]   = {BW{1'b1}};
    be_c[1]   = 32'h0000_FFFF;

    // rst_n cv cwe wv rrdy crdy wrdy rv rd | e_cv e_cwe e_crdy e_wv e_wrdy e_rv e_rrdy e_gnt e_busy own
    vecs[0]  = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 0};
    vecs[1]  = '{1'b1, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 0};
    vecs[2]  = '{1'b1, 2'b01, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 1'b1, 2'b01, 1'b1, 0};
    vecs[3]  = '{1'b1, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 1'b1, 2'b01, 1'b1, 0};
    vecs[4]  = '{1'b1, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 1'b1, 2'b01, 1'b1, 0};
    vecs[5]  = '{1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 0};
    vecs[6]  = '{1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 2'b10, 1'b1, 1};
    vecs[7]  = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 0};
    vecs[8]  = '{1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 0};
    vecs[9]  = '{1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00, 1'b1, 2'b01, 1'b1, 0};
    vecs[10] = '{1'b1, 2'b10, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 2'b01, 1'b1, 0};
    vecs[11] = '{1'b1, 2'b10, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 1'b1, 16'h1111, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b01, 1'b1, 2'b01, 1'b1, 0};
    vecs[12] = '{1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 0};
    vecs[13] = '{1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 2'b10, 1'b0, 2'b00, 2'b00, 1'b1, 2'b10, 1'b1, 1};
    vecs[14] = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 16'h2222, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b10, 1'b1, 2'b10, 1'b1, 1};
    vecs[15] = '{1'b1, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 0};
    vecs[16] = '{1'b1, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 2'b01, 1'b1, 0};
    vecs[17] = '{1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00, 1'b1, 2'b01, 1'b1, 0};
    vecs[18] = '{1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 0};
    vecs[19] = '{1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00, 1'b1, 2'b01, 1'b1, 0};
    vecs[20] = '{1'b1, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 16'h3333, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b01, 1'b0, 2'b01, 1'b1, 0};
    vecs[21] = '{1'b1, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 16'h3333, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b01, 1'b0, 2'b01, 1'b1, 0};
    vecs[22] = '{1'b1, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 16'h3333, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b01, 1'b0, 2'b01, 1'b1, 0};
    vecs[23] = '{1'b1, 2'b10, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 1'b1, 16'h3333, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b01, 1'b1, 2'b01, 1'b1, 0};
    vecs[24] = '{1'b1, 2'b10, 2'b10, 2'b00, 2'b11, 1'b0, 1'b0, 1'b1, 16'h4444, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 0};
    vecs[25] = '{1'b1, 2'b10, 2'b10, 2'b00, 2'b11, 1'b1, 1'b0, 1'b1, 16'h4444, 1'b1, 1'b1, 2'b10, 1'b0, 2'b00, 2'b00, 1'b1, 2'b10, 1'b1, 1};
    vecs[26] = '{1'b1, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 1'b1, 2'b10, 1'b1, 1};
    vecs[27] = '{1'b0, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 0};
    vecs[28] = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 0};
    vecs[29] = '{1'b1, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 0};

    req_cmd_addr       = {addr_c[1], addr_c[0]};
    req_wdata_data     = {dat_c[1], dat_c[0]};
    req_wdata_we       = {be_c[1], be_c[0]};
    sys_rst_n          = 1'b0;
    req_cmd_valid      = '0;
    req_cmd_we         = '0;
    req_wdata_valid    = '0;
    req_rdata_ready    = '0;
    cmd_ready          = 1'b0;
    wdata_ready        = 1'b0;
    rdata_valid        = 1'b0;
    rdata_payload_data = '0;
    repeat (2) @(posedge sys_clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      v                  = vecs[i];
      sys_rst_n          = v.rst_n;
      req_cmd_valid      = v.cv;
      req_cmd_we         = v.cwe;
      req_wdata_valid    = v.wv;
      req_rdata_ready    = v.rrdy;
      cmd_ready          = v.crdy;
      wdata_ready        = v.wrdy;
      rdata_valid        = v.rv;
      rdata_payload_data = {16{v.rd}};
      #1;
      chk("cmd_valid", i, cmd_valid, v.e_cv);
      chk("req_cmd_ready", i, req_cmd_ready, v.e_crdy);
      chk("wdata_valid", i, wdata_valid, v.e_wv);
      chk("req_wdata_ready", i, req_wdata_ready, v.e_wrdy);
      chk("req_rdata_valid", i, req_rdata_valid, v.e_rv);
      chk("rdata_ready", i, rdata_ready, v.e_rrdy);
      chk("grant", i, grant, v.e_gnt);
      chk("busy", i, busy, v.e_busy);
      chk("timeout_err", i, timeout_err, 0);
      chk_w("req_rdata_data", i, req_rdata_data, {16{v.rd}});
      if (v.e_cv) begin
        exp_last = !v.e_cwe;
        chk("cmd_we", i, cmd_payload_we, v.e_cwe);
        chk("cmd_last", i, cmd_last, exp_last);
        chk("cmd_addr", i, cmd_payload_addr, addr_c[v.e_own]);
      end
      if (v.e_wv) begin
        chk_w("wdata_data", i, wdata_payload_data, dat_c[v.e_own]);
        chk("wdata_be", i, wdata_payload_we, be_c[v.e_own]);
      end
      @(posedge sys_clk);
      #1;
    end

    // Async reset landing mid-cycle while a write is waiting for its data beat.
    req_wdata_valid = '0;
    wdata_ready     = 1'b0;
    rdata_valid     = 1'b0;
    req_rdata_ready = '0;
    req_cmd_valid   = 2'b10;
    req_cmd_we      = 2'b10;
    n = 0;
    #1;
    while (!cmd_valid && n < 20) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    chk("hs_cmd_latency", 100, n, 1);
    chk("hs_grant_cmd", 100, grant, 2'b10);
    cmd_ready = 1'b1;
    @(posedge sys_clk);
    #1;
    cmd_ready       = 1'b0;
    req_cmd_valid   = '0;
    req_wdata_valid = 2'b10;
    #1;
    chk("hs_wdata_valid", 101, wdata_valid, 1);
    @(negedge sys_clk);
    #2;
    sys_rst_n   = 1'b0;
    wdata_ready = 1'b1;
    #1;
    chk("hs_rst_grant", 102, grant, 2'b00);
    chk("hs_rst_busy", 102, busy, 0);
    chk("hs_rst_wdata_valid", 102, wdata_valid, 0);
    chk("hs_rst_req_wdata_ready", 102, req_wdata_ready, 2'b00);
    chk("hs_rst_cmd_valid", 102, cmd_valid, 0);
    chk("hs_rst_rdata_ready", 102, rdata_ready, 1);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    chk("hs_post_rst_busy", 103, busy, 0);
    chk("hs_post_rst_grant", 103, grant, 2'b00);

`ifdef NATIVE_ARB_TIMEOUT_EN
    // Unanswered read on port 0 is released after 16 RDATA cycles; port 1 is next.
    req_wdata_valid = '0;
    wdata_ready     = 1'b0;
    req_rdata_ready = 2'b11;
    req_cmd_valid   = 2'b01;
    req_cmd_we      = 2'b00;
    cmd_ready       = 1'b1;
    @(posedge sys_clk);
    #1;
    @(posedge sys_clk);
    #1;
    req_cmd_valid = 2'b10;
    cmd_ready     = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      chk("to_pulse", 200 + c, timeout_err, (c == 16) ? 1 : 0);
      chk("to_grant", 200 + c, grant, 2'b01);
      @(posedge sys_clk);
      #1;
    end
    chk("to_idle_grant", 217, grant, 2'b00);
    chk("to_idle_err", 217, timeout_err, 0);
    @(posedge sys_clk);
    #1;
    chk("to_next_grant", 218, grant, 2'b10);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
